dmem_bus_ctrl: RTL and testbench

- Data-memory controller between the single-cycle core's load/store datapath and a slower, handshaked memory bus.
- Registers each core load/store and holds the core with `core_stall` while the access is in flight.
- Generates byte enables for byte, half and word accesses, and returns sign- or zero-extended load data.
- Flags misaligned accesses and bus timeouts with a one-cycle fault.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/dmem_bus_ctrl_if.sv | 24 ++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_bus_ctrl.sv | 151 +++++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the core's data-memory path: access sizes, controller
// states and the illegal-access decode used by the bus controller.
package mips_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] RESP = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    localparam int TIMEOUT_DEFAULT = 255;

    // Access attributes held for the whole bus transaction.
    typedef struct packed {
        logic        we;
        logic        uns;
        logic [1:0]  size;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic access_illegal(input logic [1:0] size,
                                            input logic [1:0] off,
                                            input logic       re,
                                            input logic       we);
        return (re & we)
             | ((size == SIZE_HALF) & off[0])
             | ((size == SIZE_WORD) & (off != 2'b00))
             | (size == 2'b11);
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Handshaked memory bus between the data-memory controller (master) and the
// memory or cache behind it (slave).
interface dmem_bus_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [3:0]        mem_req_be;
    logic [31:0]       mem_req_wdata;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: byte enables and replicated store data on
// the way out, lane select plus sign/zero extension on the way back.
module dmem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_off_i,
    input  logic [1:0]  st_size_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,

    input  logic [1:0]  ld_off_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = ld_raw_i[gi*8 +: 8];
    end

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SIZE_BYTE: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel  = lane[ld_off_i];
        half_sel  = ld_off_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
        ld_data_o = ld_raw_i;
        case (ld_size_i)
            SIZE_BYTE: ld_data_o = ld_unsigned_i ? {24'b0, byte_sel}
                                                 : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: ld_data_o = ld_unsigned_i ? {16'b0, half_sel}
                                                 : {{16{half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory controller: registers one core load/store, runs it over the
// handshaked bus while stalling the core, and returns extended load data.
module dmem_bus_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_re,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [1:0]        core_size,
    input  logic              core_unsigned,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_fault,

    dmem_bus_ctrl_if.master   mem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:2] addr_q, addr_d;
    dmem_req_t         req_q, req_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        req_any;
    logic        illegal;
    logic        tmo_hit;
    logic        req_valid;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign req_any = core_re | core_we;
    assign illegal = access_illegal(core_size, core_addr[1:0], core_re, core_we);
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT));

    // Store side steers the live core request; load side uses the latched one.
    dmem_lane_align u_align (
        .st_off_i      (core_addr[1:0]),
        .st_size_i     (core_size),
        .st_wdata_i    (core_wdata),
        .st_be_o       (st_be),
        .st_wdata_o    (st_wdata),
        .ld_off_i      (req_q.off),
        .ld_size_i     (req_q.size),
        .ld_unsigned_i (req_q.uns),
        .ld_raw_i      (mem.mem_resp_rdata),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        core_stall = 1'b0;
        core_fault = 1'b0;
        req_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (illegal) begin
                        core_fault = 1'b1;
                    end else begin
                        core_stall  = 1'b1;
                        addr_d      = core_addr[ADDR_W-1:2];
                        req_d.we    = core_we;
                        req_d.uns   = core_unsigned;
                        req_d.size  = core_size;
                        req_d.off   = core_addr[1:0];
                        req_d.be    = st_be;
                        req_d.wdata = st_wdata;
                        cnt_d       = '0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                core_stall = 1'b1;
                if (tmo_hit) begin
                    core_fault = 1'b1;
                    rdata_d    = '0;
                    state_d    = DONE;
                end else begin
                    req_valid = 1'b1;
                    if (mem.mem_req_ready) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                core_stall = 1'b1;
                if (tmo_hit) begin
                    core_fault = 1'b1;
                    rdata_d    = '0;
                    state_d    = DONE;
                end else if (mem.mem_resp_valid) begin
                    // A store's response is only an acknowledge; its data is not returned.
                    rdata_d = req_q.we ? 32'b0 : ld_data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    assign core_rdata = (state_q == DONE) ? DATA_W'(rdata_q) : '0;

    assign mem.mem_req_valid = req_valid;
    assign mem.mem_req_we    = req_valid & req_q.we;
    assign mem.mem_req_addr  = req_valid ? {addr_q, 2'b00} : '0;
    assign mem.mem_req_be    = req_valid ? req_q.be : 4'b0000;
    assign mem.mem_req_wdata = req_valid ? req_q.wdata : 32'b0;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: a vector table of single accesses with an
// always-ready memory, plus hand sequences for faults, slow ack, timeout, reset.
module tb_dmem_bus_ctrl;
    import mips_pkg::*;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        core_re;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [1:0]  core_size;
    logic        core_unsigned;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_fault;

    int total;
    int bad;

    dmem_bus_ctrl_if #(.ADDR_W(32)) bus ();

    dmem_bus_ctrl #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_re       (core_re),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_size     (core_size),
        .core_unsigned (core_unsigned),
        .core_stall    (core_stall),
        .core_rdata    (core_rdata),
        .core_fault    (core_fault),
        .mem           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] raw;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " stall"}, 32'(core_stall), 32'd0);
        chk({tag, " fault"}, 32'(core_fault), 32'd0);
        chk({tag, " rdata"}, core_rdata, 32'd0);
        chk({tag, " valid"}, 32'(bus.mem_req_valid), 32'd0);
    endtask

    task automatic drop_core();
        core_re       = 1'b0;
        core_we       = 1'b0;
        core_addr     = 32'd0;
        core_wdata    = 32'd0;
        core_size     = SIZE_WORD;
        core_unsigned = 1'b0;
    endtask

    // Entered and left at a falling edge with the controller in IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = v.raw;
        core_re       = ~v.we;
        core_we       = v.we;
        core_addr     = v.addr;
        core_wdata    = v.wdata;
        core_size     = v.size;
        core_unsigned = v.uns;
        #1;
        chk({t, " idle stall"}, 32'(core_stall), 32'd1);
        chk({t, " idle valid"}, 32'(bus.mem_req_valid), 32'd0);
        @(negedge clk);
        chk({t, " req valid"}, 32'(bus.mem_req_valid), 32'd1);
        chk({t, " req addr"}, bus.mem_req_addr, v.exp_addr);
        chk({t, " req be"}, 32'(bus.mem_req_be), 32'(v.exp_be));
        chk({t, " req wdata"}, bus.mem_req_wdata, v.exp_wdata);
        chk({t, " req we"}, 32'(bus.mem_req_we), 32'(v.we));
        chk({t, " req stall"}, 32'(core_stall), 32'd1);
        @(negedge clk);
        chk({t, " resp stall"}, 32'(core_stall), 32'd1);
        chk({t, " resp valid"}, 32'(bus.mem_req_valid), 32'd0);
        @(negedge clk);
        chk({t, " done stall"}, 32'(core_stall), 32'd0);
        chk({t, " done fault"}, 32'(core_fault), 32'd0);
        chk({t, " done rdata"}, core_rdata, v.exp_rdata);
        $display("txn %s we=%0d addr=%h be=%b rdata=%h", t, v.we, v.addr, bus.mem_req_be, core_rdata);
        drop_core();
        @(negedge clk);
        chk_quiet({t, " after"});
    endtask

    logic [31:0] ill_addr [4];
    logic [1:0]  ill_size [4];
    logic        ill_re   [4];
    logic        ill_we   [4];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drop_core();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'd0;

        //           we  size       uns addr          wdata         raw           exp_addr      be       exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, SIZE_WORD, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, SIZE_BYTE, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, SIZE_HALF, 1'b0, 32'h0000_0102, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_80FF};
        vecs[4]  = '{1'b0, SIZE_HALF, 1'b1, 32'h0000_0100, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 4'b0011, 32'h0,        32'h0000_FF7F};
        vecs[5]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h0000_0100, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 4'b0001, 32'h0,        32'h0000_007F};
        vecs[6]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h0000_0101, 32'h0,        32'h80FF_FF7F, 32'h0000_0100, 4'b0010, 32'h0,        32'hFFFF_FFFF};
        vecs[7]  = '{1'b0, SIZE_HALF, 1'b0, 32'h0000_0102, 32'h0,        32'h7FFF_0000, 32'h0000_0100, 4'b1100, 32'h0,        32'h0000_7FFF};
        vecs[8]  = '{1'b1, SIZE_BYTE, 1'b0, 32'h0000_0305, 32'h0000_00A5, 32'h0,        32'h0000_0304, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[9]  = '{1'b1, SIZE_WORD, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[10] = '{1'b1, SIZE_HALF, 1'b0, 32'h0000_0200, 32'h1111_BEEF, 32'h0,        32'h0000_0200, 4'b0011, 32'hBEEF_BEEF, 32'h0};
        vecs[11] = '{1'b0, SIZE_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0123_4567, 32'hFFFF_FFFC, 4'b1111, 32'h0,        32'h0123_4567};

        ill_addr[0] = 32'h102; ill_size[0] = SIZE_WORD; ill_re[0] = 1'b1; ill_we[0] = 1'b0;
        ill_addr[1] = 32'h101; ill_size[1] = SIZE_HALF; ill_re[1] = 1'b1; ill_we[1] = 1'b0;
        ill_addr[2] = 32'h100; ill_size[2] = 2'b11;     ill_re[2] = 1'b0; ill_we[2] = 1'b1;
        ill_addr[3] = 32'h100; ill_size[3] = SIZE_WORD; ill_re[3] = 1'b1; ill_we[3] = 1'b1;

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("post-reset");

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Illegal requests: one-cycle fault, no stall, no bus request.
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_re   = ill_re[i];
            core_we   = ill_we[i];
            core_addr = ill_addr[i];
            core_size = ill_size[i];
            #1;
            chk($sformatf("ill%0d fault", i), 32'(core_fault), 32'd1);
            chk($sformatf("ill%0d stall", i), 32'(core_stall), 32'd0);
            chk($sformatf("ill%0d valid", i), 32'(bus.mem_req_valid), 32'd0);
            $display("txn ill%0d re=%0d we=%0d addr=%h size=%b fault=%0d", i, ill_re[i], ill_we[i], ill_addr[i], ill_size[i], core_fault);
            drop_core();
            @(negedge clk);
            chk_quiet($sformatf("ill%0d after", i));
        end

        // sh at 0x206 with a late write acknowledge.
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        core_we    = 1'b1;
        core_addr  = 32'h206;
        core_wdata = 32'h1234_ABCD;
        core_size  = SIZE_HALF;
        #1;
        chk("sh idle stall", 32'(core_stall), 32'd1);
        @(negedge clk);
        chk("sh req valid", 32'(bus.mem_req_valid), 32'd1);
        chk("sh req addr", bus.mem_req_addr, 32'h204);
        chk("sh req be", 32'(bus.mem_req_be), 32'hC);
        chk("sh req wdata", bus.mem_req_wdata, 32'hABCD_ABCD);
        chk("sh req we", 32'(bus.mem_req_we), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("sh wait%0d stall", c), 32'(core_stall), 32'd1);
        end
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        chk("sh done stall", 32'(core_stall), 32'd0);
        chk("sh done fault", 32'(core_fault), 32'd0);
        $display("txn sh addr=206 acked stall=%0d", core_stall);
        drop_core();
        @(negedge clk);
        chk_quiet("sh after");

        // Timeout in REQ: ready never comes.
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'hFFFF_FFFF;
        core_re   = 1'b1;
        core_addr = 32'h100;
        core_size = SIZE_WORD;
        #1;
        chk("tmo idle stall", 32'(core_stall), 32'd1);
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            chk($sformatf("tmo req%0d valid", c), 32'(bus.mem_req_valid), 32'd1);
            chk($sformatf("tmo req%0d fault", c), 32'(core_fault), 32'd0);
        end
        @(negedge clk);
        chk("tmo fault", 32'(core_fault), 32'd1);
        chk("tmo valid drop", 32'(bus.mem_req_valid), 32'd0);
        @(negedge clk);
        chk("tmo done stall", 32'(core_stall), 32'd0);
        chk("tmo done rdata", core_rdata, 32'd0);
        chk("tmo done fault", 32'(core_fault), 32'd0);
        $display("txn timeout addr=100 rdata=%h", core_rdata);
        drop_core();
        @(negedge clk);
        chk_quiet("tmo after");

        // Reset while waiting in RESP, then a stale response after release.
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'h5555_5555;
        core_re   = 1'b1;
        core_addr = 32'h100;
        core_size = SIZE_WORD;
        @(negedge clk);
        @(negedge clk);
        chk("rst resp stall", 32'(core_stall), 32'd1);
        rst = 1'b0;
        drop_core();
        @(negedge clk);
        chk_quiet("rst hold");
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        chk_quiet("rst stale");
        @(negedge clk);
        chk_quiet("rst stale2");
        $display("txn reset-in-resp stale ignored");
        run_vec(99, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
